// File: rtl/spc2_cfg_tx_if.sv
// Host-side handshake bundle for the spc2 serial configuration transmitter.
// The master drives start/Cfg_word; the slave (transmitter) returns ready/busy/done.
interface spc2_cfg_tx_if;
    logic        start;
    logic [15:0] Cfg_word;
    logic        ready;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output Cfg_word,
        input  ready,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  Cfg_word,
        output ready,
        output busy,
        output done
    );
endinterface

// File: rtl/spc2_cfg_tx.sv
// Serial configuration transmitter for the spc2 receiver: reset pulse, 16 bits LSB first, latch edge.
// Optional one-deep request queue enabled by defining SPC2_CFG_TX_QUEUE_EN.
module spc2_cfg_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic         Clk,
    input  logic         Resetn,
    spc2_cfg_tx_if.slave cfg,
    output logic         Cfg_out,
    output logic         Cfg_clk,
    output logic         Cfg_rstn
);

    localparam int unsigned MaxCnt = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] RstLast = CntW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StRst, StLow, StHigh, StTail, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_q;
    logic [15:0]     word_q;
    logic            busy_q;
    logic            done_q;
    logic            cfg_out_q;
    logic            cfg_clk_q;
    logic            cfg_rstn_q;
    logic            accept;

`ifdef SPC2_CFG_TX_QUEUE_EN
    logic [15:0] shadow_q;
    logic        shadow_full_q;

    assign cfg.ready = !shadow_full_q;
`else
    assign cfg.ready = !busy_q;
`endif

    assign accept   = cfg.start && cfg.ready;
    assign cfg.busy = busy_q;
    assign cfg.done = done_q;
    assign Cfg_out  = cfg_out_q;
    assign Cfg_clk  = cfg_clk_q;
    assign Cfg_rstn = cfg_rstn_q;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_out_q  <= 1'b0;
            cfg_clk_q  <= 1'b0;
            cfg_rstn_q <= 1'b0;
`ifdef SPC2_CFG_TX_QUEUE_EN
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
`ifdef SPC2_CFG_TX_QUEUE_EN
                    // A word parked during the previous DONE cycle launches first.
                    if (shadow_full_q) begin
                        word_q        <= shadow_q;
                        shadow_full_q <= 1'b0;
                        state_q       <= StRst;
                        busy_q        <= 1'b1;
                        bit_q         <= '0;
                        cnt_q         <= '0;
                        cfg_rstn_q    <= 1'b0;
                        cfg_out_q     <= 1'b0;
                        cfg_clk_q     <= 1'b0;
                    end else if (accept) begin
`else
                    if (accept) begin
`endif
                        word_q     <= cfg.Cfg_word;
                        state_q    <= StRst;
                        busy_q     <= 1'b1;
                        bit_q      <= '0;
                        cnt_q      <= '0;
                        cfg_rstn_q <= 1'b0;
                        cfg_out_q  <= 1'b0;
                        cfg_clk_q  <= 1'b0;
                    end
                end
                StRst: begin
                    if (cnt_q == RstLast) begin
                        cnt_q      <= '0;
                        state_q    <= StLow;
                        cfg_rstn_q <= 1'b1;
                        cfg_out_q  <= word_q[bit_q];
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StLow: begin
                    if (cnt_q == DivLast) begin
                        cnt_q     <= '0;
                        state_q   <= StHigh;
                        cfg_clk_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHigh: begin
                    if (cnt_q == DivLast) begin
                        cnt_q     <= '0;
                        cfg_clk_q <= 1'b0;
                        if (bit_q == 4'd15) begin
                            state_q <= StTail;
                        end else begin
                            // Data only moves together with the falling edge into LOW.
                            bit_q     <= bit_q + 4'd1;
                            cfg_out_q <= word_q[bit_q + 4'd1];
                            state_q   <= StLow;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StTail: begin
                    if (cnt_q == DivLast) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
`ifdef SPC2_CFG_TX_QUEUE_EN
                    if (shadow_full_q) begin
                        word_q        <= shadow_q;
                        shadow_full_q <= 1'b0;
                        state_q       <= StRst;
                        bit_q         <= '0;
                        cnt_q         <= '0;
                        cfg_rstn_q    <= 1'b0;
                        cfg_out_q     <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
`ifdef SPC2_CFG_TX_QUEUE_EN
            if (accept && busy_q) begin
                shadow_q      <= cfg.Cfg_word;
                shadow_full_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_spc2_cfg_tx.sv
// Scoreboard bench for spc2_cfg_tx: two instances (CLK_DIV=4/RST=2 and 1/1) and a receiver model.
// Follows SPC2_CFG_TX_QUEUE_EN for the queue-dependent scenario.
module tb_spc2_cfg_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spc2_cfg_tx_if ifa ();
    spc2_cfg_tx_if ifb ();

    logic [1:0] cout_w, cclk_w, rstn_w, busy_w, done_w, ready_w;

    assign busy_w  = {ifb.busy, ifa.busy};
    assign done_w  = {ifb.done, ifa.done};
    assign ready_w = {ifb.ready, ifa.ready};

    spc2_cfg_tx #(.CLK_DIV(4), .RST_CYCLES(2)) dut_a (
        .Clk      (clk),
        .Resetn   (rst_n),
        .cfg      (ifa),
        .Cfg_out  (cout_w[0]),
        .Cfg_clk  (cclk_w[0]),
        .Cfg_rstn (rstn_w[0])
    );

    spc2_cfg_tx #(.CLK_DIV(1), .RST_CYCLES(1)) dut_b (
        .Clk      (clk),
        .Resetn   (rst_n),
        .cfg      (ifb),
        .Cfg_out  (cout_w[1]),
        .Cfg_clk  (cclk_w[1]),
        .Cfg_rstn (rstn_w[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic s, input logic [15:0] w);
        if (idx == 0) begin
            ifa.start    = s;
            ifa.Cfg_word = w;
        end else begin
            ifb.start    = s;
            ifb.Cfg_word = w;
        end
    endtask

    // Receiver model: shift on Cfg_clk rise, latch on the falling edge after 16 bits.
    logic [15:0] exp_q[$];
    logic [15:0] sr[2];
    logic [15:0] rx_out[2];
    int          edge_cnt[2];
    logic        prev_clk[2];

    always @(negedge clk) begin
        logic [15:0] head;
        for (int d = 0; d < 2; d++) begin
            if (!rstn_w[d]) begin
                edge_cnt[d] = 0;
            end else if (cclk_w[d] && !prev_clk[d]) begin
                if (edge_cnt[d] >= 16) begin
                    check_eq("extra_edge", edge_cnt[d], 15);
                end else if (exp_q.size() > 0) begin
                    head = exp_q[0];
                    check_eq("bit", cout_w[d], head[edge_cnt[d][3:0]]);
                end
                sr[d] = {cout_w[d], sr[d][15:1]};
                edge_cnt[d]++;
            end else if (!cclk_w[d] && prev_clk[d] && edge_cnt[d] == 16) begin
                rx_out[d]   = sr[d];
                edge_cnt[d] = 0;
                if (exp_q.size() > 0) check_eq("rx_word", sr[d], exp_q.pop_front());
                else check_eq("rx_unexp_q", exp_q.size(), 1);
            end
            prev_clk[d] = cclk_w[d];
        end
    end

    // Sends one word and measures the busy window; optional second start at busy cycle inj_at.
    task automatic run_frame(input int idx, input logic [15:0] w, input int exp_busy,
                             input int exp_dones, input int exp_high, input int inj_at,
                             input logic [15:0] inj_w, input bit inj_pushes);
        int   cnt, dones, first_done, last_done, high_cyc, trans;
        logic pc, rstn_after, ended;
        @(negedge clk);
        drive(idx, 1'b1, w);
        exp_q.push_back(w);
        @(negedge clk);
        drive(idx, 1'b0, 16'h0);
        cnt = 0; dones = 0; first_done = 0; last_done = 0; high_cyc = 0; trans = 0;
        pc = 1'b0; rstn_after = 1'b1; ended = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) @(negedge clk);
            if (!busy_w[idx]) begin
                ended = 1'b1;
                break;
            end
            cnt++;
            if (done_w[idx]) begin
                dones++;
                last_done = cnt;
                if (first_done == 0) first_done = cnt;
            end
            if (first_done != 0 && cnt == first_done + 1) rstn_after = rstn_w[idx];
            if (cclk_w[idx]) high_cyc++;
            if (cclk_w[idx] != pc) trans++;
            pc = cclk_w[idx];
            if (inj_at != 0 && cnt == inj_at) begin
                drive(idx, 1'b1, inj_w);
                if (inj_pushes) exp_q.push_back(inj_w);
            end
            if (inj_at != 0 && cnt == inj_at + 1) begin
                drive(idx, 1'b0, 16'h0);
                check_eq("ready_after_inj", ready_w[idx], 0);
            end
        end
        check_eq("frame_ended", ended, 1);
        check_eq("busy_len", cnt, exp_busy);
        check_eq("done_count", dones, exp_dones);
        check_eq("done_last", last_done, exp_busy);
        check_eq("clk_high_cycles", high_cyc, exp_high);
        check_eq("clk_transitions", trans, 32 * exp_dones);
        if (exp_dones > 1) check_eq("rst_after_done", rstn_after, 0);
    endtask

    initial begin
        int busy_seen, dones;
        logic reached;
        for (int d = 0; d < 2; d++) begin
            sr[d] = '0; rx_out[d] = '0; edge_cnt[d] = 0; prev_clk[d] = 1'b0;
        end
        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cfg_out", cout_w[0], 0);
        check_eq("rst_cfg_clk", cclk_w[0], 0);
        check_eq("rst_cfg_rstn", rstn_w[0], 0);
        check_eq("rst_busy", busy_w[0], 0);
        check_eq("rst_done", done_w[0], 0);
        check_eq("rst_ready", ready_w[0], 1);
        check_eq("rst_ready_b", ready_w[1], 1);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_rstn_low", rstn_w[0], 0);

        run_frame(0, 16'hA5C3, 135, 1, 64, 0, 16'h0, 1'b0);
        check_eq("rx_F", rx_out[0][15:12], 4'hA);
        check_eq("rx_IQ", rx_out[0][11], 0);
        check_eq("rx_GS", rx_out[0][10:7], 4'hB);
        check_eq("rx_CE", rx_out[0][6], 1);
        check_eq("rx_NS", rx_out[0][5], 0);
        check_eq("rx_GD", rx_out[0][4:2], 0);
        check_eq("rx_FS", rx_out[0][1], 1);
        check_eq("rx_RE", rx_out[0][0], 1);
        @(negedge clk);
        check_eq("idle_rstn_high", rstn_w[0], 1);

`ifdef SPC2_CFG_TX_QUEUE_EN
        run_frame(0, 16'h1234, 270, 2, 128, 20, 16'h8000, 1'b1);
        check_eq("q_rx_F", rx_out[0][15:12], 4'h8);
        check_eq("q_rx_rest", rx_out[0][11:0], 0);
`else
        run_frame(0, 16'hA5C3, 135, 1, 64, 20, 16'hFFFF, 1'b0);
        check_eq("hold_rx", rx_out[0], 16'hA5C3);
        busy_seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (busy_w[0]) busy_seen++;
        end
        check_eq("no_second_frame", busy_seen, 0);
`endif

        // Abort mid-frame after the 8th rising edge.
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF);
        exp_q.push_back(16'hFFFF);
        @(negedge clk);
        drive(0, 1'b0, 16'h0);
        reached = 1'b0;
        dones = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (done_w[0]) dones++;
            if (edge_cnt[0] == 8) begin
                reached = 1'b1;
                break;
            end
        end
        check_eq("abort_reach_8", reached, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_cfg_out", cout_w[0], 0);
        check_eq("abort_cfg_clk", cclk_w[0], 0);
        check_eq("abort_cfg_rstn", rstn_w[0], 0);
        check_eq("abort_busy", busy_w[0], 0);
        check_eq("abort_done", done_w[0], 0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            if (done_w[0]) dones++;
        end
        check_eq("abort_no_done", dones, 0);

        run_frame(0, 16'h0001, 135, 1, 64, 0, 16'h0, 1'b0);
        check_eq("after_abort_rx", rx_out[0], 16'h0001);

        run_frame(1, 16'h5555, 35, 1, 16, 0, 16'h0, 1'b0);
        check_eq("div1_F", rx_out[1][15:12], 4'h5);
        check_eq("div1_GS", rx_out[1][10:7], 4'hA);
        check_eq("div1_GD", rx_out[1][4:2], 3'b101);
        check_eq("div1_RE", rx_out[1][0], 1);

        repeat (4) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spc2_cfg_tx.md
Name: spc2_cfg_tx

Overview:
- Serial configuration transmitter that drives the spc2 serial configuration receiver.
- Accepts a 16-bit configuration word over a valid/ready handshake, then emits one frame on the receiver's Cfg_in/Clk/Resetn pins:
  - a receiver reset pulse,
  - 16 data bits LSB first,
  - a trailing falling edge that fires the receiver's latch strobe.
- Sits in the digital control domain, between the register file/host interface and the spc2 receiver.

Parameters:
- CLK_DIV, 4, system clocks per half-period of Cfg_clk (must be >= 1).
- RST_CYCLES, 2, system clocks Cfg_rstn is held low at frame start (must be >= 1).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Resetn  input  1  synchronous active-low reset.
- start  input  1  request to send Cfg_word; accepted when start && ready.
- Cfg_word  input  16  packing {F[3:0], IQ, GS[3:0], CE, NS, GD[2:0], FS, RE}, bit15..bit0.
- ready  output  1  block can accept start this cycle.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- Cfg_out  output  1  serial data to receiver Cfg_in.
- Cfg_clk  output  1  serial clock to receiver Clk.
- Cfg_rstn  output  1  to receiver Resetn; re-aligns its bit counter each frame.

Behaviour:
- All outputs registered; no combinational input-to-output paths except ready.
- Reset (Resetn=0 at a Clk edge): state IDLE, Cfg_out=0, Cfg_clk=0, Cfg_rstn=0, busy=0, done=0, counters and word register cleared.
- Reset mid-frame aborts the frame immediately, with no done pulse.
- Cfg_rstn stays 0 after reset until the first frame's RST phase ends. After that it is 1 in IDLE.
- ready = !busy (without the macro).
- start while !ready is ignored; a captured word is never modified mid-frame.
- States: IDLE -> RST -> LOW -> HIGH -> (LOW | TAIL) -> DONE -> IDLE.
- IDLE:
  - On accepted start, latch Cfg_word and bit index=0.
  - Next cycle: state RST, busy=1.
- RST: Cfg_rstn=0, Cfg_clk=0, Cfg_out=0 for RST_CYCLES cycles, then LOW.
- LOW:
  - Cfg_rstn=1, Cfg_clk=0, Cfg_out=word[bit index] for CLK_DIV cycles.
  - Data changes only on entry to LOW, so it has CLK_DIV cycles of setup before the rising edge.
- HIGH:
  - Cfg_clk=1 for CLK_DIV cycles; Cfg_out held.
  - Then if bit index==15 go to TAIL, else bit index+1 and go to LOW.
- TAIL: Cfg_clk=0, Cfg_out held, for CLK_DIV cycles. This falling edge is the receiver latch strobe (count==0 & ~Clk).
- DONE: one cycle with busy=1, done=1, Cfg_clk=0; then IDLE.
- Bit order follows from the receiver's right shift: the first bit sent (word[0], RE) ends in receiver out[0]; the last (word[15]) ends in out[15].
- Exactly 16 rising edges of Cfg_clk per frame.
- Cfg_clk is low whenever not in HIGH.
- Latency:
  - busy is high for RST_CYCLES + 33*CLK_DIV + 1 cycles, starting the cycle after acceptance.
  - done is high in the last of those cycles.
- Counter widths sized from parameters: phase counter >= clog2(max(CLK_DIV,RST_CYCLES)+1), bit index 4 bits. No wrap inside a frame.

Optional Feature:
- Macro SPC2_CFG_TX_QUEUE_EN.
- When defined:
  - A one-deep shadow register exists; ready = !shadow_full.
  - start accepted while busy loads the shadow.
  - In the DONE cycle, if shadow_full, the shadow is moved to the word register and the next state is RST instead of IDLE (busy stays 1).
  - start in the DONE cycle with shadow empty is accepted into the shadow and is transmitted after the current frame's DONE, one frame later.
  - Reset clears shadow_full.
- When undefined: no shadow register; ready = !busy.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles -> Cfg_out=0, Cfg_clk=0, Cfg_rstn=0, busy=0, done=0, ready=1.
- Single frame, CLK_DIV=4, RST_CYCLES=2: start with Cfg_word=16'hA5C3 ->
  - busy high 135 cycles, done on the 135th;
  - 16 Cfg_clk rising edges, Cfg_out at edge k = bit k-1;
  - receiver model shows F=4'hA, IQ=0, GS=4'hB, CE=1, NS=0, GD=0, FS=1, RE=1.
- Macro off: second start with 16'hFFFF at cycle 20 of a frame -> ignored; ready=0; receiver holds the 16'hA5C3 fields; no second frame.
- Resetn=0 for 1 cycle after the 8th rising edge -> next cycle all outputs at reset values, no done. Then start 16'h0001 -> receiver RE=1, all other fields 0.
- Macro on: start 16'h1234 then start 16'h8000 during the frame ->
  - ready=0 after the second accept;
  - RST of frame 2 begins the cycle after frame 1's done;
  - receiver ends with F=4'h8, other fields 0.
- CLK_DIV=1, RST_CYCLES=1: start 16'h5555 -> busy 35 cycles, Cfg_clk alternates each cycle in LOW/HIGH, receiver F=5, GS=4'hA, GD=3'b101, RE=1.
